// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - decode operand forwarding plus per-register load-use countdown scoreboard.
// Optional stall statistics counter is built when ID_SB_STATS_EN is defined.
module id_scoreboard #(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_FWD    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  input  logic                                 issue_we,
  input  logic [ADDR_W-1:0]                    issue_waddr,
  input  logic                                 issue_is_load,
  input  logic                                 stall_pipe,
  input  logic                                 flush,
  input  logic [NUM_RPORTS*ADDR_W-1:0]         raddr,
  input  logic [NUM_RPORTS-1:0]                rread_en,
  input  logic [NUM_RPORTS*DATA_W-1:0]         rf_rdata,
  input  logic [NUM_FWD*(1+ADDR_W+DATA_W)-1:0] fwd_bus,
  output logic [NUM_RPORTS*DATA_W-1:0]         rdata,
  output logic                                 stallreq,
  output logic [31:0]                          stall_cycles
);

  localparam int FW    = 1 + ADDR_W + DATA_W;
  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(LOAD_LAT);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             fire;

  // Scan sources oldest to youngest so the lowest index wins.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rdata[p*DATA_W +: DATA_W] = rf_rdata[p*DATA_W +: DATA_W];
      for (int s = NUM_FWD - 1; s >= 0; s--) begin
        if (fwd_bus[s*FW + ADDR_W + DATA_W] &&
            (fwd_bus[s*FW + DATA_W +: ADDR_W] == raddr[p*ADDR_W +: ADDR_W]))
          rdata[p*DATA_W +: DATA_W] = fwd_bus[s*FW +: DATA_W];
      end
      if (raddr[p*ADDR_W +: ADDR_W] == '0)
        rdata[p*DATA_W +: DATA_W] = '0;
    end
  end

  always_comb begin
    stallreq = 1'b0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (rread_en[p] && (raddr[p*ADDR_W +: ADDR_W] != '0) &&
          (cnt_q[raddr[p*ADDR_W +: ADDR_W]] != '0))
        stallreq = 1'b1;
    end
  end

  assign fire = issue_valid & ~stallreq & ~stall_pipe & ~flush;

  always_comb begin
    for (int r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
    if (flush) begin
      for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
    end else if (!stall_pipe) begin
      for (int r = 0; r < NREG; r++)
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
      // A non-load write supersedes a pending load; its result is forwarded.
      if (fire && issue_we && (issue_waddr != '0))
        cnt_d[issue_waddr] = issue_is_load ? LAT_V : '0;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifdef ID_SB_STATS_EN
  logic [31:0] stat_q;
  logic [31:0] stat_d;

  always_comb begin
    stat_d = stat_q;
    if (stallreq && !flush && (stat_q != 32'hFFFF_FFFF))
      stat_d = stat_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stat_q <= '0;
    else      stat_q <= stat_d;
  end

  assign stall_cycles = stat_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
